sid_mixer: RTL and testbench
============================

// Module: sid_mixer
// PURPOSE
//  Mixes the three signed voice outputs into one 8-bit unsigned sample for pwm_audio.
//  Per-voice mute, 4-bit master volume, midscale offset, saturation.
//  Sequential: one shared adder, shift-add multiply, one sample per sample_strobe.
//  Holds its output between updates so the PWM stage always sees a stable sample.
// PARAMETERS
//  VW     12  voice sample width (signed two's complement)
//  SHIFT  8   arithmetic right shift applied to (sum*volume) before offset
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   reset, asynchronous, active-low
//  voice0         in   VW  voice 0 sample, signed
//  voice1         in   VW  voice 1 sample, signed
//  voice2         in   VW  voice 2 sample, signed
//  mute           in   3   mute[i]=1 -> voice i contributes 0
//  volume         in   4   master volume, unsigned 0..15
//  sample_strobe  in   1   one-cycle pulse, start a new mix
//  sample         out  8   mixed unsigned sample, to pwm_audio.sample
//  sample_valid   out  1   one-cycle pulse when sample is updated
//  busy           out  1   high while a mix is in progress (state != IDLE)
//  overrun        out  1   one-cycle pulse when a strobe arrives while busy
// BEHAVIOUR
//  Reset: state=IDLE, sample=8'h80 (silence, 50% duty), sample_valid=0, busy=0,
//   overrun=0, accumulators cleared. Reset mid-mix aborts it; no valid pulse is issued.
//  States: IDLE -> ACC (3 clk) -> MUL (4 clk) -> OUT (1 clk) -> IDLE.
//  IDLE: on the edge where sample_strobe=1, register voice0..2, mute and volume;
//   clear acc. Later input changes do not affect the mix in progress.
//  ACC: a 2-bit index steps 0,1,2; acc += mute[i] ? 0 : sext(voice[i]).
//   acc is VW+2 bits signed; no overflow is possible.
//  MUL: shift-add over volume bits 0..3, LSB first; prod += vol[k] ? acc<<k : 0.
//   prod is VW+6 bits signed. Result is the exact signed product acc*volume.
//  OUT: t = (prod >>> SHIFT) + 128, evaluated signed with no truncation before the clamp.
//   sample = t<0 ? 0 : t>255 ? 255 : t[7:0]; sample_valid=1 for this cycle only.
//  Latency: sample and sample_valid change 8 clocks after the strobe-capture edge.
//   A strobe is accepted at most once every 9 clocks.
//  The >>> is a floor shift: -1 >>> 8 = -1, not 0.
//  volume=0 or all voices muted -> sample=128.
//  Strobe while busy (ACC/MUL/OUT): ignored, overrun pulses for 1 clk,
//   and the current mix completes unchanged.
//  A strobe in the same cycle as OUT is also an overrun. The next strobe is taken only in IDLE.
//  sample holds its last value indefinitely between mixes.
//  A strobe wider than 1 clk starts one mix; each later high cycle while busy raises overrun.
// TESTING
//  1 Reset: after rst_n release -> sample=0x80, busy=0, no sample_valid pulse.
//  2 voice0=256, voice1=voice2=0, vol=8, strobe
//    -> sample=136, sample_valid exactly 8 clk after capture.
//  3 All voices=2047, vol=15 -> 6141*15>>8=359+128 -> clamps to 255.
//    All voices=-2048, vol=15 -> clamps to 0.
//  4 Floor rounding: voice0=-1, others 0, vol=1 -> 127.
//    Same inputs with vol=0 -> 128.
//  5 Mute: voices 100,200,300, mute=3'b010, vol=15 -> 400*15>>8=23 -> 151.
//    Change the inputs 2 clk after the strobe -> result is still 151.
//  6 Second strobe 3 clk after the first -> overrun pulse, single sample_valid, correct value.
//    Assert rst_n mid-MUL -> sample=0x80, no valid pulse.

Source files
------------

// File: rtl/sid_mixer.sv
// Three-voice mixer: a sequential mute/sum, a shift-add volume multiply, then an offset and clamp
// to an unsigned 8-bit sample. One shared adder serves both the sum and the multiply.
module sid_mixer #(
  parameter int VW    = 12,
  parameter int SHIFT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [VW-1:0] voice0,
  input  logic signed [VW-1:0] voice1,
  input  logic signed [VW-1:0] voice2,
  input  logic [2:0]           mute,
  input  logic [3:0]           volume,
  input  logic                 sample_strobe,
  output logic [7:0]           sample,
  output logic                 sample_valid,
  output logic                 busy,
  output logic                 overrun
);

  // state | meaning
  // IDLE  | waiting for sample_strobe, inputs captured on the strobe edge
  // ACC   | 3 clk: acc += voice[i] unless muted, i = 0..2
  // MUL   | 4 clk: prod += acc << k when volume bit k is set, k = 0..3
  // OUT   | 1 clk: offset, clamp and register the sample
  typedef enum logic [1:0] {IDLE, ACC, MUL, OUT} state_t;

  localparam int AW = VW + 2;
  localparam int PW = VW + 6;
  localparam int QW = PW - SHIFT;
  localparam int TW = ((QW > 9) ? QW : 9) + 1;

  state_t state, state_next;

  logic signed [VW-1:0] voice_r [3];
  logic [2:0]           mute_r;
  logic [3:0]           vol_r;
  logic signed [AW-1:0] acc;
  logic signed [PW-1:0] prod;
  logic [1:0]           cnt;

  logic signed [VW-1:0] voice_sel;
  logic signed [PW-1:0] add_a, add_b, add_sum;
  logic signed [TW-1:0] t;
  logic [7:0]           clamped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (sample_strobe) state_next = ACC;
      ACC:  if (cnt == 2'd2)   state_next = MUL;
      MUL:  if (cnt == 2'd3)   state_next = OUT;
      OUT:                     state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_comb begin
    case (cnt)
      2'd0:    voice_sel = voice_r[0];
      2'd1:    voice_sel = voice_r[1];
      default: voice_sel = voice_r[2];
    endcase
  end

  // Shared adder: voice accumulation in ACC, partial-product accumulation in MUL.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (state == ACC) begin
      add_a = PW'(acc);
      add_b = mute_r[cnt] ? '0 : PW'(voice_sel);
    end else if (state == MUL) begin
      add_a = prod;
      add_b = vol_r[cnt] ? (PW'(acc) <<< cnt) : '0;
    end
    add_sum = add_a + add_b;
  end

  // Floor shift then offset, kept wide enough that the clamp sees the true value.
  always_comb begin
    t = TW'(prod >>> SHIFT) + TW'(128);
    if (t[TW-1])           clamped = 8'd0;
    else if (t > TW'(255)) clamped = 8'd255;
    else                   clamped = t[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voice_r[0]   <= '0;
      voice_r[1]   <= '0;
      voice_r[2]   <= '0;
      mute_r       <= '0;
      vol_r        <= '0;
      acc          <= '0;
      prod         <= '0;
      cnt          <= '0;
      sample       <= 8'h80;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      overrun      <= sample_strobe && (state != IDLE);
      case (state)
        IDLE: if (sample_strobe) begin
          voice_r[0] <= voice0;
          voice_r[1] <= voice1;
          voice_r[2] <= voice2;
          mute_r     <= mute;
          vol_r      <= volume;
          acc        <= '0;
          prod       <= '0;
          cnt        <= '0;
        end
        ACC: begin
          acc <= AW'(add_sum);
          cnt <= (cnt == 2'd2) ? 2'd0 : cnt + 2'd1;
        end
        MUL: begin
          prod <= add_sum;
          cnt  <= cnt + 2'd1;
        end
        OUT: begin
          sample       <= clamped;
          sample_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sid_mixer.sv
// Directed bench for sid_mixer: hand-computed mix results, latency, overrun and reset abort.
module tb_sid_mixer;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [11:0] voice0 = '0, voice1 = '0, voice2 = '0;
  logic [2:0]         mute = '0;
  logic [3:0]         volume = '0;
  logic               sample_strobe = 1'b0;
  logic [7:0]         sample;
  logic               sample_valid, busy, overrun;

  int checks = 0;
  int errors = 0;

  sid_mixer #(.VW(12), .SHIFT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .voice0(voice0), .voice1(voice1), .voice2(voice2),
    .mute(mute), .volume(volume), .sample_strobe(sample_strobe),
    .sample(sample), .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Stimulus only: one strobe, optional input change / second strobe, then observe 20 clocks.
  task automatic run_mix(input int v0, input int v1, input int v2, input logic [2:0] m,
                         input logic [3:0] vol, input int chg_at, input int second_at,
                         output int lat, output logic [7:0] s, output int nvalid,
                         output int novr, output logic busy_after);
    @(negedge clk);
    voice0 = 12'(v0); voice1 = 12'(v1); voice2 = 12'(v2);
    mute = m; volume = vol; sample_strobe = 1'b1;
    @(posedge clk); #1;
    sample_strobe = 1'b0;
    busy_after = busy;
    lat = -1; s = 8'hxx; nvalid = 0; novr = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (sample_valid) begin
        nvalid++;
        if (lat < 0) begin lat = i; s = sample; end
      end
      if (overrun) novr++;
      if (i == chg_at) begin
        voice0 = -12'sd2048; voice1 = -12'sd2048; voice2 = -12'sd2048;
        mute = 3'b000; volume = 4'd15;
      end
      sample_strobe = (i == second_at);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (sample !== 8'h80 || busy !== 1'b0 || sample_valid !== 1'b0 || overrun !== 1'b0) begin
        errors++;
        $display("FAIL reset_state cyc%0d: sample=%h busy=%b valid=%b ovr=%b, required 80/0/0/0",
                 i, sample, busy, sample_valid, overrun);
      end
    end
  endtask

  task automatic test_basic;
    int lat, nv, no; logic [7:0] s; logic b;
    run_mix(256, 0, 0, 3'b000, 4'd8, 0, 0, lat, s, nv, no, b);
    checks++;
    if (b !== 1'b1) begin errors++; $display("FAIL basic_busy: busy=%b, required 1", b); end
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d clk, required 8", lat); end
    checks++;
    if (s !== 8'd136) begin errors++; $display("FAIL basic_value: got %0d, required 136", s); end
    checks++;
    if (nv !== 1) begin errors++; $display("FAIL basic_valid_count: got %0d, required 1", nv); end
    // Sample must hold between mixes.
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (sample !== 8'd136) begin errors++; $display("FAIL basic_hold: got %0d, required 136", sample); end
  endtask

  task automatic test_values;
    int v[6][5];
    int lat, nv, no; logic [7:0] s; logic b;
    //           v0     v1     v2     vol  expected
    v[0] = '{ 2047,  2047,  2047, 15, 255};
    v[1] = '{-2048, -2048, -2048, 15,   0};
    v[2] = '{   -1,     0,     0,  1, 127};
    v[3] = '{   -1,     0,     0,  0, 128};
    v[4] = '{-1000,     0,     0,  4, 112};
    v[5] = '{ 2047,     0,     0, 15, 247};
    for (int k = 0; k < 6; k++) begin
      run_mix(v[k][0], v[k][1], v[k][2], 3'b000, 4'(v[k][3]), 0, 0, lat, s, nv, no, b);
      checks++;
      if (s !== 8'(v[k][4]) || lat !== 8) begin
        errors++;
        $display("FAIL value_vec%0d: sample=%0d lat=%0d, required %0d lat=8", k, s, lat, v[k][4]);
      end
    end
    run_mix(2047, 2047, 2047, 3'b111, 4'd15, 0, 0, lat, s, nv, no, b);
    checks++;
    if (s !== 8'd128) begin errors++; $display("FAIL all_muted: got %0d, required 128", s); end
  endtask

  task automatic test_mute;
    int lat, nv, no; logic [7:0] s; logic b;
    run_mix(100, 200, 300, 3'b010, 4'd15, 0, 0, lat, s, nv, no, b);
    checks++;
    if (s !== 8'd151) begin errors++; $display("FAIL mute_value: got %0d, required 151", s); end
    run_mix(100, 200, 300, 3'b010, 4'd15, 2, 0, lat, s, nv, no, b);
    checks++;
    if (s !== 8'd151 || lat !== 8) begin
      errors++;
      $display("FAIL mute_input_change: got %0d lat=%0d, required 151 lat=8", s, lat);
    end
  endtask

  task automatic test_overrun;
    int lat, nv, no; logic [7:0] s; logic b;
    run_mix(256, 0, 0, 3'b000, 4'd8, 0, 3, lat, s, nv, no, b);
    checks++;
    if (no !== 1) begin errors++; $display("FAIL overrun_pulses: got %0d, required 1", no); end
    checks++;
    if (nv !== 1) begin errors++; $display("FAIL overrun_valid_count: got %0d, required 1", nv); end
    checks++;
    if (s !== 8'd136 || lat !== 8) begin
      errors++;
      $display("FAIL overrun_value: got %0d lat=%0d, required 136 lat=8", s, lat);
    end
  endtask

  task automatic test_reset_mid_mix;
    int nv = 0;
    @(negedge clk);
    voice0 = 12'sd2047; voice1 = '0; voice2 = '0; mute = '0; volume = 4'd15;
    sample_strobe = 1'b1;
    @(posedge clk); #1;
    sample_strobe = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (sample !== 8'h80 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mul: sample=%h busy=%b, required 80/0", sample, busy);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (sample_valid) nv++;
    end
    checks++;
    if (nv !== 0 || sample !== 8'h80) begin
      errors++;
      $display("FAIL reset_no_valid: valid pulses=%0d sample=%h, required 0/80", nv, sample);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_mute();
    test_overrun();
    test_reset_mid_mix();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
